// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder, WIDTH bits in WIDTH/BLOCK lookahead groups.
// S1 registers bit and group generate/propagate terms. The output stage resolves the carries.
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] g,
  input  logic [BLOCK-1:0] p,
  output logic             gg,
  output logic             gp
);
  // Each generate bit is qualified by every propagate above it, so no carry ripples through the group.
  always_comb begin
    logic term;
    gg = 1'b0;
    gp = &p;
    for (int i = 0; i < BLOCK; i++) begin
      term = g[i];
      for (int k = i + 1; k < BLOCK; k++) term = term & p[k];
      gg = gg | term;
    end
  end
endmodule

module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || BLOCK < 2 || BLOCK > 8) begin : g_param_err
    $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK, BLOCK in 2..8");
  end

  logic [NG-1:0][BLOCK-1:0] p_in, g_in;
  logic [NG-1:0]            gg_in, gp_in;

  assign p_in = a ^ b;
  assign g_in = a & b;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    cla_group #(.BLOCK(BLOCK)) u_grp (
      .g  (g_in[j]),
      .p  (p_in[j]),
      .gg (gg_in[j]),
      .gp (gp_in[j])
    );
  end

  logic                     s1_valid, s1_cin;
  logic [NG-1:0][BLOCK-1:0] s1_p, s1_g;
  logic [NG-1:0]            s1_gg, s1_gp;

  logic out_adv, accept;
  assign out_adv  = s1_valid & (!out_valid | out_ready);
  assign in_ready = !s1_valid | out_adv;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cin   <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_gg    <= '0;
      s1_gp    <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_cin   <= cin;
        s1_p     <= p_in;
        s1_g     <= g_in;
        s1_gg    <= gg_in;
        s1_gp    <= gp_in;
      end else if (out_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  logic [WIDTH-1:0] sum_nx;
  logic             cout_nx, ovf_nx;

  // Group carry j is the lookahead over groups 0..j-1 and cin. It seeds the in-group bit carries.
  always_comb begin
    logic                     gc, t, cb;
    logic [NG-1:0][BLOCK-1:0] c_bits;
    c_bits  = '0;
    cout_nx = 1'b0;
    for (int j = 0; j <= NG; j++) begin
      gc = s1_cin;
      for (int k = 0; k < j; k++) gc = gc & s1_gp[k];
      for (int m = 0; m < j; m++) begin
        t = s1_gg[m];
        for (int k = m + 1; k < j; k++) t = t & s1_gp[k];
        gc = gc | t;
      end
      if (j == NG) begin
        cout_nx = gc;
      end else begin
        cb = gc;
        for (int i = 0; i < BLOCK; i++) begin
          c_bits[j][i] = cb;
          cb = s1_g[j][i] | (s1_p[j][i] & cb);
        end
      end
    end
    sum_nx = s1_p ^ c_bits;
    ovf_nx = c_bits[NG-1][BLOCK-1] ^ cout_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (out_adv) begin
        out_valid <= 1'b1;
        sum       <= sum_nx;
        cout      <= cout_nx;
        ovf       <= ovf_nx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe at 8/4, 16/4 and 32/8. All three instances share one stream.
// Expected results come from plain integer addition.
module tb_cla_adder_pipe;
  logic        clk, rst_n, in_valid, out_ready, op_c;
  logic [31:0] op_a, op_b;

  logic        rdy8, ov8, co8, of8;
  logic [7:0]  s8;
  logic        rdy16, ov16, co16, of16;
  logic [15:0] s16;
  logic        rdy32, ov32, co32, of32;
  logic [31:0] s32;

  cla_adder_pipe #(.WIDTH(8), .BLOCK(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .a(op_a[7:0]), .b(op_b[7:0]), .cin(op_c),
    .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8));
  cla_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .a(op_a[15:0]), .b(op_b[15:0]), .cin(op_c),
    .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16));
  cla_adder_pipe #(.WIDTH(32), .BLOCK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .a(op_a), .b(op_b), .cin(op_c),
    .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32), .ovf(of32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pops16   = 0;
  logic [33:0] q8[$], q16[$], q32[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Returns {ovf, cout, sum} for a w-bit add, using signed-overflow rules.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] full;
    logic [31:0] mask, xm, ym;
    logic        v;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xm   = x & mask;
    ym   = y & mask;
    full = {1'b0, xm} + {1'b0, ym} + {32'd0, c};
    v    = (xm[w-1] == ym[w-1]) && (full[w-1] != xm[w-1]);
    return {v, full[w], full[31:0] & mask};
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_valid && rdy16) begin
      q8.push_back(model(8, op_a, op_b, op_c));
      q16.push_back(model(16, op_a, op_b, op_c));
      q32.push_back(model(32, op_a, op_b, op_c));
    end
  end

  logic        prev_stall = 1'b0;
  logic [17:0] prev_out;
  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (ov8) begin
        if (q8.size() == 0) chk("unexpected_out8", 64'd1, 64'd0);
        else chk("res8", {30'd0, of8, co8, 24'd0, s8}, {30'd0, q8.pop_front()});
      end
      if (ov16) begin
        pops16++;
        if (q16.size() == 0) chk("unexpected_out16", 64'd1, 64'd0);
        else chk("res16", {30'd0, of16, co16, 16'd0, s16}, {30'd0, q16.pop_front()});
      end
      if (ov32) begin
        if (q32.size() == 0) chk("unexpected_out32", 64'd1, 64'd0);
        else chk("res32", {30'd0, of32, co32, s32}, {30'd0, q32.pop_front()});
      end
    end
    if (rst_n && prev_stall) chk("stall_hold", {45'd0, ov16, of16, co16, s16}, {45'd1, prev_out});
    prev_stall = rst_n && ov16 && !out_ready;
    prev_out   = {of16, co16, s16};
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c, output int waits);
    logic acc;
    op_a = x; op_b = y; op_c = c; in_valid = 1'b1;
    waits = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = rdy16;
      @(posedge clk); #1;
      if (!acc) begin
        waits++;
        if (waits > 200) begin
          chk("send_timeout", 64'd1, 64'd0);
          acc = 1'b1;
        end
      end
    end
  endtask

  task automatic direct(input logic [31:0] x, input logic [31:0] y, input logic c);
    int w;
    send(x, y, c, w);
    in_valid = 1'b0;
    @(negedge clk); chk("lat_k", {63'd0, ov16}, 64'd0);
    @(negedge clk); chk("lat_k1", {63'd0, ov16}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q8.size() + q16.size() + q32.size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 64'(q8.size() + q16.size() + q32.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic stream_done;
  initial begin
    int w, tot, acc;
    logic ok;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; op_c = 1'b0; stream_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {61'd0, ov8, ov16, ov32}, 64'd0);
    chk("rst_sum", {30'd0, of16, co16, s16}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {61'd0, rdy8, rdy16, rdy32}, 64'd7);

    direct(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    direct(32'h0000_7FFF, 32'h0000_0001, 1'b0);
    direct(32'h0000_8000, 32'h0000_8000, 1'b0);
    direct(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    direct(32'h8000_0080, 32'hFFFF_FFFF, 1'b0);

    // Back-to-back random stream with the consumer always ready.
    tot = 0;
    pops16 = 0;
    for (int i = 0; i < 1000; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), w);
      tot += w;
    end
    chk("stream_no_stall", 64'(tot), 64'd0);
    drain();
    chk("stream_count", 64'(pops16), 64'd1000);

    // Six cycles of backpressure into an empty pipe: only two operands fit.
    out_ready = 1'b0;
    op_a = $urandom; op_b = $urandom; op_c = 1'($urandom_range(0, 1)); in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); ok = rdy16;
      @(posedge clk); #1;
      if (ok) begin
        acc++;
        op_a = $urandom; op_b = $urandom; op_c = 1'($urandom_range(0, 1));
      end
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_in_ready", {63'd0, rdy16}, 64'd0);
    drain();

    // Random stream with random consumer readiness.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          send($urandom, $urandom, 1'($urandom_range(0, 1)), w);
        end
        in_valid = 1'b0;
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, w);
    send(32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b1, w);
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", {63'd0, rdy16}, 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {61'd0, ov8, ov16, ov32}, 64'd0);
    chk("async_rst_sum", {30'd0, of16, co16, s16}, 64'd0);
    q8.delete(); q16.delete(); q32.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {61'd0, rdy8, rdy16, rdy32}, 64'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_out", {61'd0, ov8, ov16, ov32}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
